sc_regdeserializer: RTL and testbench

Serial-to-parallel receive register that collects a qualified serial bit stream into a RegDESER_DATAWIDTH-bit word and presents it on a parallel bus with a valid/acknowledge handshake. It is the receiving end for the team's shift-register blocks, which drive words out serially. It sits between a serial source (shift register, pin sampler) and a parallel consumer (register bank, display logic).

---
 rtl/sc_regdeserializer.sv | 145 ++++++++++++++
 tb/tb_sc_regdeserializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_regdeserializer.sv
// sc_regdeserializer
//   Serial-to-parallel receive register. After a low-active start strobe in IDLE,
//   the block shifts in RegDESER_DATAWIDTH qualified serial bits, MSB- or
//   LSB-first as latched at frame start. It then presents the word on a parallel
//   bus with a valid / active-low acknowledge handshake. If an unacknowledged
//   word is overwritten, a sticky overrun flag is set.
//
// Ports
//   SC_RegDESER_CLOCK_50       in   system clock, rising edge
//   SC_RegDESER_RESET_InHigh   in   asynchronous active-high reset
//   SC_RegDESER_clear_InLow    in   synchronous clear (aborts frame, zeroes state)
//   SC_RegDESER_start_InLow    in   frame-start strobe, sampled in IDLE only
//   SC_RegDESER_msbfirst_In    in   bit order, latched at frame start
//   SC_RegDESER_serialdata_In  in   serial data bit
//   SC_RegDESER_bitvalid_In    in   qualifies serialdata_In
//   SC_RegDESER_ack_InLow      in   consumer acknowledge
//   SC_RegDESER_data_OutBUS    out  last completed word
//   SC_RegDESER_valid_Out      out  unacknowledged word present
//   SC_RegDESER_busy_Out       out  frame in progress
//   SC_RegDESER_overrun_Out    out  sticky overwrite-before-ack flag
module sc_regdeserializer #(
  parameter int unsigned RegDESER_DATAWIDTH = 8
) (
  input  logic                          SC_RegDESER_CLOCK_50,
  input  logic                          SC_RegDESER_RESET_InHigh,
  input  logic                          SC_RegDESER_clear_InLow,
  input  logic                          SC_RegDESER_start_InLow,
  input  logic                          SC_RegDESER_msbfirst_In,
  input  logic                          SC_RegDESER_serialdata_In,
  input  logic                          SC_RegDESER_bitvalid_In,
  input  logic                          SC_RegDESER_ack_InLow,
  output logic [RegDESER_DATAWIDTH-1:0] SC_RegDESER_data_OutBUS,
  output logic                          SC_RegDESER_valid_Out,
  output logic                          SC_RegDESER_busy_Out,
  output logic                          SC_RegDESER_overrun_Out
);

  localparam int unsigned W        = RegDESER_DATAWIDTH;
  localparam int unsigned CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ord_q, ord_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;

  logic [W-1:0]   shifted_c;
  logic           complete_c;

  // Shift register contents after consuming the current serial bit
  always_comb begin
    if (ord_q) shifted_c = {sr_q[W-2:0], SC_RegDESER_serialdata_In};
    else       shifted_c = {SC_RegDESER_serialdata_In, sr_q[W-1:1]};
  end

  assign complete_c = (state_q == SHIFT) && SC_RegDESER_bitvalid_In && (cnt_q == CNT_LAST);

  // Next-state and output-register logic
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ord_d     = ord_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (!SC_RegDESER_clear_InLow) begin
      state_d   = IDLE;
      sr_d      = '0;
      cnt_d     = '0;
      ord_d     = 1'b0;
      data_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!SC_RegDESER_start_InLow) begin
            state_d = SHIFT;
            sr_d    = '0;
            cnt_d   = '0;
            ord_d   = SC_RegDESER_msbfirst_In;
          end
        end
        SHIFT: begin
          if (SC_RegDESER_bitvalid_In) begin
            sr_d = shifted_c;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A completion in the ack cycle counts the old word as consumed
      if (complete_c) begin
        data_d  = shifted_c;
        valid_d = 1'b1;
        if (valid_q && SC_RegDESER_ack_InLow) overrun_d = 1'b1;
      end else if (valid_q && !SC_RegDESER_ack_InLow) begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge SC_RegDESER_CLOCK_50 or posedge SC_RegDESER_RESET_InHigh) begin
    if (SC_RegDESER_RESET_InHigh) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ord_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ord_q     <= ord_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign SC_RegDESER_data_OutBUS = data_q;
  assign SC_RegDESER_valid_Out   = valid_q;
  assign SC_RegDESER_busy_Out    = (state_q == SHIFT);
  assign SC_RegDESER_overrun_Out = overrun_q;

endmodule

// File: tb/tb_sc_regdeserializer.sv
// tb_sc_regdeserializer
//   Randomized and directed stimulus for sc_regdeserializer, with a reference
//   model that assembles each word from the list of transmitted bits and tracks
//   the valid and overrun flags.
module tb_sc_regdeserializer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         clr_n;
  logic         start_n;
  logic         msb_i;
  logic         sdata;
  logic         bvalid;
  logic         ack_n;
  logic [W-1:0] data;
  logic         valid;
  logic         busy;
  logic         ovr;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovr;

  sc_regdeserializer #(.RegDESER_DATAWIDTH(W)) dut (
    .SC_RegDESER_CLOCK_50      (clk),
    .SC_RegDESER_RESET_InHigh  (rst),
    .SC_RegDESER_clear_InLow   (clr_n),
    .SC_RegDESER_start_InLow   (start_n),
    .SC_RegDESER_msbfirst_In   (msb_i),
    .SC_RegDESER_serialdata_In (sdata),
    .SC_RegDESER_bitvalid_In   (bvalid),
    .SC_RegDESER_ack_InLow     (ack_n),
    .SC_RegDESER_data_OutBUS   (data),
    .SC_RegDESER_valid_Out     (valid),
    .SC_RegDESER_busy_Out      (busy),
    .SC_RegDESER_overrun_Out   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_zero();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Full frame: start cycle, W bits (optional gap), completion checks.
  // stream[W-1] is the first bit on the wire.
  task automatic do_frame(input logic [W-1:0] stream, input logic msb, input int gap_at,
                          input int gap_len, input bit toggle, input bit pulses, input bit ack_end);
    bit           q[$];
    logic [W-1:0] exp;
    // Start cycle: a qualified bit here must be ignored
    start_n = 1'b0;
    msb_i   = msb;
    bvalid  = 1'b1;
    sdata   = 1'($urandom);
    @(posedge clk); #1;
    start_n = 1'b1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b expected 1", busy); end
    for (int i = 0; i < int'(W); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bvalid  = 1'b0;
          sdata   = 1'($urandom);
          start_n = pulses ? 1'b0 : 1'b1;
          @(posedge clk); #1;
          start_n = 1'b1;
          total++;
          if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_gap: got %b expected 1", busy); end
        end
      end
      bvalid = 1'b1;
      sdata  = stream[W-1-i];
      q.push_back(stream[W-1-i]);
      if (toggle && i == int'(W/2)) msb_i = ~msb;
      if (pulses && i == 2) start_n = 1'b0;
      else start_n = 1'b1;
      ack_n = (i == int'(W-1) && ack_end) ? 1'b0 : 1'b1;
      if (i == int'(W-1) && !m_valid) begin
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL valid_early: got %b expected 0", valid); end
      end
      @(posedge clk); #1;
    end
    bvalid  = 1'b0;
    ack_n   = 1'b1;
    start_n = 1'b1;
    msb_i   = msb;
    // Assemble the word from the bit list: first bit lands at the MSB or LSB
    exp = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (msb) exp = exp | (W'(q[i]) << (W - 1 - i));
      else     exp = exp | (W'(q[i]) << i);
    end
    if (m_valid && !ack_end) m_ovr = 1'b1;
    m_valid = 1'b1;
    m_data  = exp;
    total++;
    if (data !== m_data) begin bad++; $display("FAIL frame_data: got %h expected %h", data, m_data); end
    total++;
    if (valid !== 1'b1) begin bad++; $display("FAIL frame_valid: got %b expected 1", valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL frame_busy: got %b expected 0", busy); end
    total++;
    if (ovr !== m_ovr) begin bad++; $display("FAIL frame_overrun: got %b expected %b", ovr, m_ovr); end
  endtask

  // Start plus n bits, left unfinished
  task automatic partial(input int n);
    start_n = 1'b0;
    msb_i   = 1'b1;
    @(posedge clk); #1;
    start_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      bvalid = 1'b1;
      sdata  = 1'($urandom);
      @(posedge clk); #1;
    end
    bvalid = 1'b0;
  endtask

  // One idle cycle, optionally acknowledging
  task automatic idle(input bit ack);
    ack_n = ~ack;
    @(posedge clk); #1;
    ack_n = 1'b1;
    if (ack) m_valid = 1'b0;
    total++;
    if (valid !== m_valid) begin bad++; $display("FAIL idle_valid: got %b expected %b", valid, m_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b0; clr_n = 1'b1; start_n = 1'b1; msb_i = 1'b1;
    sdata = 1'b0; bvalid = 1'b0; ack_n = 1'b1;
    #1 rst = 1'b1;
    #1;
    model_zero();
    total++;
    if ({data, valid, busy, ovr} !== '0) begin
      bad++; $display("FAIL reset_state: got data=%h v=%b b=%b o=%b expected all 0", data, valid, busy, ovr);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_msb_first();
    do_frame(8'hB2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (data !== 8'hB2) begin bad++; $display("FAIL msb_word: got %h expected b2", data); end
    idle(1'b1);
    total++;
    if (data !== 8'hB2) begin bad++; $display("FAIL data_after_ack: got %h expected b2", data); end
  endtask

  task automatic test_lsb_first();
    do_frame(8'hB2, 1'b0, -1, 0, 1'b1, 1'b0, 1'b0);
    total++;
    if (data !== 8'h4D) begin bad++; $display("FAIL lsb_word: got %h expected 4d", data); end
    idle(1'b1);
  endtask

  task automatic test_gapped();
    do_frame(8'hB2, 1'b1, 4, 3, 1'b0, 1'b1, 1'b0);
    total++;
    if (data !== 8'hB2) begin bad++; $display("FAIL gapped_word: got %h expected b2", data); end
    idle(1'b1);
  endtask

  task automatic test_overrun();
    do_frame(8'hB2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    do_frame(8'h0F, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({data, valid, ovr} !== {8'h0F, 1'b1, 1'b1}) begin
      bad++; $display("FAIL overrun_set: got data=%h v=%b o=%b expected 0f 1 1", data, valid, ovr);
    end
    clr_n = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    model_zero();
    do_frame(8'hB2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    do_frame(8'h0F, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({data, valid, ovr} !== {8'h0F, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ack_on_completion: got data=%h v=%b o=%b expected 0f 1 0", data, valid, ovr);
    end
  endtask

  task automatic test_clear_mid();
    partial(4);
    clr_n = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    model_zero();
    total++;
    if ({data, valid, busy, ovr} !== '0) begin
      bad++; $display("FAIL clear_mid: got data=%h v=%b b=%b o=%b expected all 0", data, valid, busy, ovr);
    end
    do_frame(8'hB2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (data !== 8'hB2) begin bad++; $display("FAIL word_after_clear: got %h expected b2", data); end
  endtask

  task automatic test_reset_mid();
    partial(4);
    #2 rst = 1'b1;
    #1;
    model_zero();
    total++;
    if ({data, valid, busy, ovr} !== '0) begin
      bad++; $display("FAIL reset_mid: got data=%h v=%b b=%b o=%b expected all 0", data, valid, busy, ovr);
    end
    @(negedge clk); rst = 1'b0;
    do_frame(8'hB2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (data !== 8'hB2) begin bad++; $display("FAIL word_after_reset: got %h expected b2", data); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      do_frame(W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, W - 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gapped();
    test_overrun();
    test_clear_mid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
